// File: rtl/ysyx_22040931_if_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one fetch outstanding, and
// holds the fetched instruction in a single-entry IF/ID buffer for decode.
module ysyx_22040931_if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_KILL} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] req_pc_q, req_pc_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic        req_fire;

  // Only request when the buffer is free or draining this cycle, so a response
  // can never land on top of an unconsumed instruction.
  assign imem_req_valid = (state_q == S_REQ) && !redirect_valid && (!out_valid_q || out_ready);
  assign imem_addr      = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_instr = out_instr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_instr_d = out_instr_q;
    if (redirect_valid) begin
      pc_d        = redirect_pc;
      out_valid_d = 1'b0;
      // An in-flight fetch is wrong-path; its response must still be absorbed.
      case (state_q)
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_KILL;
        S_KILL:  state_d = imem_rsp_valid ? S_REQ : S_KILL;
        default: state_d = S_REQ;
      endcase
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            req_pc_d = pc_q;
            pc_d     = pc_q + 64'd4;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            out_valid_d = 1'b1;
            out_pc_d    = req_pc_q;
            out_instr_d = imem_rsp_data;
            state_d     = S_REQ;
          end
        end
        S_KILL: begin
          if (imem_rsp_valid) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      req_pc_q    <= 64'd0;
      out_valid_q <= 1'b0;
      out_pc_q    <= 64'd0;
      out_instr_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_instr_q <= out_instr_d;
    end
  end
endmodule

// File: tb/tb_ysyx_22040931_if_stage.sv
// Bench for the fetch stage: transaction-level model plus a latency-programmable
// memory responder; instruction data is the bitwise inverse of the fetch address.
module tb_ysyx_22040931_if_stage;
  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'd0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_pc;
  logic [31:0] out_instr;

  ysyx_22040931_if_stage dut (
    .clock(clock), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr)
  );

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // Model: is a fetch outstanding, is it doomed, what does the buffer hold.
  logic        m_busy = 1'b0, m_kill = 1'b0, m_bv = 1'b0;
  logic [63:0] m_pc = RST_PC, m_rpc = 64'd0, m_bpc = 64'd0;
  logic [31:0] m_bi = 32'd0;
  bit          started = 1'b0;

  // Values present at the upcoming active edge, captured on the falling edge.
  logic        c_rst = 1'b1, c_redir = 1'b0, c_rsp = 1'b0, c_ordy = 1'b0, c_hs = 1'b0, c_dhs = 1'b0;
  logic [63:0] c_rdpc = 64'd0, c_daddr = 64'd0;
  logic [31:0] c_rspd = 32'd0;

  int          lat = 1;
  int          mcnt = 0;
  bit          mpend = 1'b0;
  logic [63:0] maddr = 64'd0;

  function automatic logic exp_rv();
    return !m_busy && !redirect_valid && (!m_bv || out_ready);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    c_rst   = reset;
    c_redir = redirect_valid;
    c_rdpc  = redirect_pc;
    c_rsp   = imem_rsp_valid;
    c_rspd  = imem_rsp_data;
    c_ordy  = out_ready;
    c_hs    = exp_rv() && imem_req_ready;
    c_dhs   = imem_req_valid && imem_req_ready;
    c_daddr = imem_addr;
    if (started) begin
      chk("imem_req_valid", {63'd0, imem_req_valid}, {63'd0, exp_rv()});
      if (exp_rv()) chk("imem_addr", imem_addr, m_pc);
      chk("out_valid", {63'd0, out_valid}, {63'd0, m_bv});
      chk("out_pc", out_pc, m_bpc);
      chk("out_instr", {32'd0, out_instr}, {32'd0, m_bi});
    end
  end

  // Advance one clock: update model and memory from what the edge saw.
  task automatic step();
    @(posedge clock);
    #1;
    started = 1'b1;
    if (c_rst) begin
      m_pc = RST_PC; m_busy = 1'b0; m_kill = 1'b0; m_bv = 1'b0;
      m_bpc = 64'd0; m_bi = 32'd0; m_rpc = 64'd0;
    end else begin
      if (c_ordy && m_bv) m_bv = 1'b0;
      if (c_rsp) begin
        if (!m_kill && !c_redir) begin
          m_bv = 1'b1; m_bpc = m_rpc; m_bi = c_rspd;
        end
        m_busy = 1'b0; m_kill = 1'b0;
      end
      if (c_redir) begin
        m_bv = 1'b0; m_pc = c_rdpc;
        if (m_busy) m_kill = 1'b1;
      end
      if (c_hs) begin
        m_busy = 1'b1; m_rpc = m_pc; m_pc = m_pc + 64'd4;
      end
    end
    imem_rsp_valid = 1'b0;
    if (c_rst) mpend = 1'b0;
    else if (c_dhs) begin
      mpend = 1'b1; mcnt = lat; maddr = c_daddr;
    end
    if (mpend) begin
      if (mcnt == 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = ~maddr[31:0];
        mpend = 1'b0;
      end else mcnt--;
    end
  endtask

  initial begin
    step(); step();
    chk("rst out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst out_pc", out_pc, 64'd0);
    chk("rst out_instr", {32'd0, out_instr}, 64'd0);
    reset = 1'b0;
    #1;
    chk("first req_valid", {63'd0, imem_req_valid}, 64'd1);
    chk("first addr", imem_addr, 64'h8000_0000);

    // Zero-wait streaming: one instruction every two cycles.
    step(); step();
    chk("s1 out_valid", {63'd0, out_valid}, 64'd1);
    chk("s1 out_pc", out_pc, 64'h8000_0000);
    chk("s1 out_instr", {32'd0, out_instr}, 64'h7FFF_FFFF);
    chk("s1 addr2", imem_addr, 64'h8000_0004);
    step(); step();
    chk("s1 out_pc2", out_pc, 64'h8000_0004);
    chk("s1 out_instr2", {32'd0, out_instr}, 64'h7FFF_FFFB);
    chk("s1 addr3", imem_addr, 64'h8000_0008);

    // Decode stall with a full buffer.
    out_ready = 1'b0;
    #1;
    chk("stall req_valid", {63'd0, imem_req_valid}, 64'd0);
    repeat (4) step();
    chk("stall hold pc", out_pc, 64'h8000_0004);
    chk("stall hold req", {63'd0, imem_req_valid}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("unstall req", {63'd0, imem_req_valid}, 64'd1);
    chk("unstall addr", imem_addr, 64'h8000_0008);
    step(); step();

    // Redirect while waiting; response arrives a cycle later and is dropped.
    lat = 2;
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    step();
    redirect_valid = 1'b0;
    step();
    chk("kill out_valid", {63'd0, out_valid}, 64'd0);
    chk("redir addr", imem_addr, 64'h8000_0100);
    lat = 1;
    step(); step();
    chk("redir out_pc", out_pc, 64'h8000_0100);
    chk("redir out_instr", {32'd0, out_instr}, 64'h7FFF_FEFF);

    // Redirect coincident with a response.
    step();
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0200;
    step();
    redirect_valid = 1'b0;
    chk("coinc out_valid", {63'd0, out_valid}, 64'd0);
    chk("coinc addr", imem_addr, 64'h8000_0200);

    // Redirect with a full, stalled buffer.
    step(); step();
    out_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0300;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("full redir out_valid", {63'd0, out_valid}, 64'd0);
    chk("full redir addr", imem_addr, 64'h8000_0300);

    // Reset while waiting on a slow response.
    lat = 3;
    step(); step();
    reset = 1'b1;
    step();
    chk("midrst out_valid", {63'd0, out_valid}, 64'd0);
    reset = 1'b0;
    imem_req_ready = 1'b0;
    #1;
    chk("midrst addr", imem_addr, 64'h8000_0000);

    // Memory back-pressure: PC must not advance until accepted.
    step(); step();
    chk("bp addr", imem_addr, 64'h8000_0000);
    step();
    imem_req_ready = 1'b1; lat = 1;
    #1;
    chk("bp accept req", {63'd0, imem_req_valid}, 64'd1);
    chk("bp accept addr", imem_addr, 64'h8000_0000);
    step(); step();
    chk("bp out_pc", out_pc, 64'h8000_0000);

    // PC wraps past the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("wrap out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap addr", imem_addr, 64'd0);

    // Mixed back-pressure, latencies and redirects.
    for (int i = 0; i < 48; i++) begin
      out_ready      = (i % 5) != 3;
      imem_req_ready = (i % 4) != 2;
      lat            = 1 + (i % 3);
      redirect_valid = (i == 17) || (i == 31) || (i == 40);
      redirect_pc    = 64'h8000_2000 + 64'(i * 16);
      step();
    end
    redirect_valid = 1'b0; out_ready = 1'b1; imem_req_ready = 1'b1;
    repeat (8) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
